// File: rtl/prio_code_change_fifo_if.sv
// prio_code_change_fifo_if: code sample input, FWFT read port and status bundle
interface prio_code_change_fifo_if #(
  parameter int DEPTH  = 4,
  parameter int CODE_W = 8
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [CODE_W-1:0] code_in;
  logic              code_valid;
  logic              rd_en;
  logic              clr_ovf;
  logic [CODE_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic [CW-1:0]     count;
  logic [7:0]        chg_cnt;
  logic              overflow;
  modport master (
    output code_in, code_valid, rd_en, clr_ovf,
    input  rd_data, rd_valid, full, count, chg_cnt, overflow
  );
  modport slave (
    input  code_in, code_valid, rd_en, clr_ovf,
    output rd_data, rd_valid, full, count, chg_cnt, overflow
  );
endinterface

// File: rtl/prio_code_change_fifo.sv
// prio_code_change_fifo: pushes each new encoder code into a FWFT FIFO, counts changes, flags drops
module prio_code_change_fifo #(
  parameter int              DEPTH         = 4,
  parameter int              CODE_W        = 8,
  parameter logic [CODE_W-1:0] NULL_CODE   = CODE_W'(8'hF0),
  parameter bit              SUPPRESS_NULL = 1'b0
) (
  input logic clk,
  input logic rst,
  prio_code_change_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [CODE_W-1:0] mem [DEPTH];
  logic [CODE_W-1:0] last_code;
  logic [AW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     cnt;
  logic [7:0]        chg;
  logic              ovf;
  logic              change, push, pop, is_full, wr, drop;
  always_comb begin
    change  = bus.code_valid && (bus.code_in != last_code);
    push    = change && !(SUPPRESS_NULL && bus.code_in == NULL_CODE);
    pop     = bus.rd_en && (cnt != '0);
    is_full = cnt == CW'(DEPTH);
    wr      = push && (!is_full || pop);
    drop    = push && is_full && !pop;
  end
  always_ff @(posedge clk)
    if (!rst && wr) mem[wr_ptr] <= bus.code_in;
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      cnt       <= '0;
      chg       <= '0;
      ovf       <= 1'b0;
      last_code <= NULL_CODE;
    end else begin
      if (change) begin
        last_code <= bus.code_in;
        chg       <= chg + 8'd1;
      end
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(wr) - CW'(pop);
      ovf <= drop || (ovf && !bus.clr_ovf);
    end
  end
  // head and status come straight from state registers, never from this cycle's inputs
  assign bus.rd_valid = cnt != '0;
  assign bus.rd_data  = (cnt != '0) ? mem[rd_ptr] : '0;
  assign bus.full     = is_full;
  assign bus.count    = cnt;
  assign bus.chg_cnt  = chg;
  assign bus.overflow = ovf;
endmodule

// File: tb/tb_prio_code_change_fifo.sv
// tb_prio_code_change_fifo: random + directed stimulus against a queue model, plain and null-suppressing builds
module tb_prio_code_change_fifo;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;
  prio_code_change_fifo_if #(.DEPTH(4), .CODE_W(8)) if0 ();
  prio_code_change_fifo_if #(.DEPTH(4), .CODE_W(8)) if1 ();
  prio_code_change_fifo #(.DEPTH(4), .CODE_W(8), .NULL_CODE(8'hF0), .SUPPRESS_NULL(1'b0)) u0 (
    .clk(clk), .rst(rst), .bus(if0));
  prio_code_change_fifo #(.DEPTH(4), .CODE_W(8), .NULL_CODE(8'hF0), .SUPPRESS_NULL(1'b1)) u1 (
    .clk(clk), .rst(rst), .bus(if1));
  always #5 clk = ~clk;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] last_m [2];
  logic [7:0] chg_m [2];
  logic       ovf_m [2];
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic model(input int k, input logic cv, input logic [7:0] code,
                       input logic rd, input logic clr, input logic r);
    logic [7:0] q[$];
    bit pop, change, push, accept, drop;
    if (k == 0) q = q0; else q = q1;
    if (r) begin
      q.delete();
      last_m[k] = 8'hF0;
      chg_m[k]  = 8'd0;
      ovf_m[k]  = 1'b0;
    end else begin
      pop    = rd && q.size() > 0;
      change = cv && code != last_m[k];
      push   = change && !(k == 1 && code == 8'hF0);
      accept = push && (q.size() < 4 || pop);
      drop   = push && !accept;
      if (change) begin
        last_m[k] = code;
        chg_m[k]  = chg_m[k] + 8'd1;
      end
      if (drop) ovf_m[k] = 1'b1;
      else if (clr) ovf_m[k] = 1'b0;
      if (pop) void'(q.pop_front());
      if (accept) q.push_back(code);
    end
    if (k == 0) q0 = q; else q1 = q;
  endtask
  task automatic compare(input int k);
    logic [7:0] q[$];
    logic [7:0] d, c, n;
    logic v, f, o;
    if (k == 0) begin
      q = q0; d = if0.rd_data; v = if0.rd_valid; f = if0.full;
      n = 8'(if0.count); c = if0.chg_cnt; o = if0.overflow;
    end else begin
      q = q1; d = if1.rd_data; v = if1.rd_valid; f = if1.full;
      n = 8'(if1.count); c = if1.chg_cnt; o = if1.overflow;
    end
    check($sformatf("u%0d.rd_valid", k), 32'(v), 32'(q.size() > 0));
    check($sformatf("u%0d.rd_data", k), 32'(d), q.size() > 0 ? 32'(q[0]) : 32'd0);
    check($sformatf("u%0d.count", k), 32'(n), 32'(q.size()));
    check($sformatf("u%0d.full", k), 32'(f), 32'(q.size() == 4));
    check($sformatf("u%0d.chg_cnt", k), 32'(c), 32'(chg_m[k]));
    check($sformatf("u%0d.overflow", k), 32'(o), 32'(ovf_m[k]));
  endtask
  task automatic step(input logic cv, input logic [7:0] code, input logic rd,
                      input logic clr, input logic r);
    if0.code_valid = cv; if0.code_in = code; if0.rd_en = rd; if0.clr_ovf = clr;
    if1.code_valid = cv; if1.code_in = code; if1.rd_en = rd; if1.clr_ovf = clr;
    rst = r;
    @(posedge clk);
    model(0, cv, code, rd, clr, r);
    model(1, cv, code, rd, clr, r);
    #1;
    compare(0);
    compare(1);
  endtask
  task automatic drain();
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask
  logic [7:0] pool [6] = '{8'h00, 8'h01, 8'h02, 8'hF0, 8'h0E, 8'h05};
  logic [7:0] seq2 [5] = '{8'h0E, 8'h0E, 8'h05, 8'h05, 8'h00};
  logic [7:0] seq5 [3] = '{8'h03, 8'hF0, 8'h03};
  initial begin
    last_m = '{8'hF0, 8'hF0};
    chg_m  = '{8'd0, 8'd0};
    ovf_m  = '{1'b0, 1'b0};
    for (int i = 0; i < 2; i++)
      step(1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b1);
    check("reset.count", 32'(if0.count), 32'd0);
    step(1'b1, 8'hF0, 1'b0, 1'b0, 1'b0);
    check("null_first.rd_valid", 32'(if0.rd_valid), 32'd0);
    step(1'b1, seq2[0], 1'b0, 1'b0, 1'b0);
    check("latency.rd_data", 32'(if0.rd_data), 32'h0E);
    for (int i = 1; i < 5; i++) step(1'b1, seq2[i], 1'b0, 1'b0, 1'b0);
    check("seq.count", 32'(if0.count), 32'd3);
    check("seq.chg_cnt", 32'(if0.chg_cnt), 32'd3);
    drain();
    step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h07, 1'b0, 1'b0, 1'b0);
    check("drop.overflow", 32'(if0.overflow), 32'd1);
    check("drop.count", 32'(if0.count), 32'd4);
    check("drop.head", 32'(if0.rd_data), 32'h11);
    drain();
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("clr.overflow", 32'(if0.overflow), 32'd0);
    step(1'b1, 8'h0A, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h0B, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h0C, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h0D, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h09, 1'b1, 1'b0, 1'b0);
    check("fullpp.count", 32'(if0.count), 32'd4);
    check("fullpp.overflow", 32'(if0.overflow), 32'd0);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check("fullpp.last", 32'(if0.rd_data), 32'h09);
    drain();
    step(1'b1, 8'h05, 1'b1, 1'b0, 1'b0);
    check("empty_push_pop.count", 32'(if0.count), 32'd1);
    drain();
    for (int i = 0; i < 3; i++) step(1'b1, seq5[i], 1'b0, 1'b0, 1'b0);
    check("suppress.count", 32'(if1.count), 32'd2);
    check("plain.count", 32'(if0.count), 32'd3);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 257; i++) step(1'b1, (i % 2 == 0) ? 8'h01 : 8'h02, 1'b1, 1'b0, 1'b0);
    check("wrap.chg_cnt", 32'(if0.chg_cnt), 32'd1);
    check("wrap.overflow", 32'(if0.overflow), 32'd0);
    step(1'b1, 8'h01, 1'b1, 1'b0, 1'b1);
    check("midrst.rd_valid", 32'(if0.rd_valid), 32'd0);
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0),
           ($urandom_range(0, 7) == 0) ? 8'($urandom) : pool[$urandom_range(0, 5)],
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 49) == 0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
